// File: rtl/regfile_wr_arb_2x.sv
// rtl/regfile_wr_arb_2x.sv - round-robin two-requester write arbiter for a 4x4 regfile
// Optional post-reset zeroing sequence enabled by defining REGFILE_WR_ARB_CLEAR_EN.
module regfile_wr_arb_2x (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_val,
    output logic       req0_rdy,
    input  logic [1:0] req0_addr,
    input  logic [3:0] req0_data,
    input  logic       req1_val,
    output logic       req1_rdy,
    input  logic [1:0] req1_addr,
    input  logic [3:0] req1_data,
    output logic       rf_wen,
    output logic [1:0] rf_waddr,
    output logic [3:0] rf_wdata,
    output logic       init_done
);

`ifdef REGFILE_WR_ARB_CLEAR_EN
    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] cnt;
    logic       in_arb;
    logic       clear_wen;

    assign in_arb    = (state == ARB);
    assign clear_wen = ~rst & ~in_arb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= 2'd0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    cnt <= cnt;
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end
`else
    logic in_arb;

    assign in_arb = 1'b1;
`endif

    logic pri;
    logic active;
    logic grant0;
    logic grant1;
    logic [1:0] arb_addr;
    logic [3:0] arb_data;

    // Grants are pure AND/OR of val so an X on val reaches rf_wen instead of being masked.
    assign active = ~rst & in_arb;
    assign grant0 = active & req0_val & (~req1_val | ~pri);
    assign grant1 = active & req1_val & (~req0_val | pri);

    assign arb_addr = ({2{grant0}} & req0_addr) | ({2{grant1}} & req1_addr);
    assign arb_data = ({4{grant0}} & req0_data) | ({4{grant1}} & req1_data);

    assign req0_rdy  = grant0;
    assign req1_rdy  = grant1;
    assign init_done = active;

`ifdef REGFILE_WR_ARB_CLEAR_EN
    assign rf_wen   = clear_wen | grant0 | grant1;
    assign rf_waddr = clear_wen ? cnt : arb_addr;
    assign rf_wdata = clear_wen ? 4'b0000 : arb_data;
`else
    assign rf_wen   = grant0 | grant1;
    assign rf_waddr = arb_addr;
    assign rf_wdata = arb_data;
`endif

    // The winner of a transfer hands priority to the other side; idle cycles keep it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri <= 1'b0;
        end else if (grant0) begin
            pri <= 1'b1;
        end else if (grant1) begin
            pri <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arb_2x.sv
// tb/tb_regfile_wr_arb_2x.sv - directed self-checking bench for regfile_wr_arb_2x
module tb_regfile_wr_arb_2x;

    logic       clk;
    logic       rst;
    logic       req0_val;
    logic       req0_rdy;
    logic [1:0] req0_addr;
    logic [3:0] req0_data;
    logic       req1_val;
    logic       req1_rdy;
    logic [1:0] req1_addr;
    logic [3:0] req1_data;
    logic       rf_wen;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic       init_done;

    int checks;
    int failures;

    logic [9:0] obs;
    assign obs = {req0_rdy, req1_rdy, rf_wen, rf_waddr, rf_wdata, init_done};

    regfile_wr_arb_2x dut (
        .clk       (clk),
        .rst       (rst),
        .req0_val  (req0_val),
        .req0_rdy  (req0_rdy),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req1_val  (req1_val),
        .req1_rdy  (req1_rdy),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] vec(input logic r0, input logic r1, input logic w,
                                       input logic [1:0] a, input logic [3:0] d,
                                       input logic done);
        return {r0, r1, w, a, d, done};
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [1:0] a0, input logic [3:0] d0,
                         input logic v1, input logic [1:0] a1, input logic [3:0] d1);
        req0_val  = v0;
        req0_addr = a0;
        req0_data = d0;
        req1_val  = v1;
        req1_addr = a1;
        req1_data = d1;
    endtask

    // Check mid-cycle, then advance to just after the next rising edge.
    task automatic cycle_check(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    localparam logic [9:0] IDLE  = 10'b0000000001;
    localparam logic [9:0] ZEROS = 10'b0000000000;

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef REGFILE_WR_ARB_CLEAR_EN
        for (int k = 0; k < 4; k++) begin
            cycle_check("clear_write", vec(1'b0, 1'b0, 1'b1, k[1:0], 4'h0, 1'b0));
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b1, 2'd3, 4'hF, 1'b0, 2'd0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        cycle_check("reset_outputs", ZEROS);

`ifdef REGFILE_WR_ARB_CLEAR_EN
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle_check("clear_a0", vec(1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0));
        cycle_check("clear_a1", vec(1'b0, 1'b0, 1'b1, 2'd1, 4'h0, 1'b0));
        @(negedge clk);
        check("clear_a2", obs, vec(1'b0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0));
        #1;
        rst = 1'b1;
        #1;
        check("mid_clear_reset", obs, ZEROS);
        release_reset();
        cycle_check("init_done_rise", IDLE);
        drive(1'b1, 2'd3, 4'hF, 1'b0, 2'd0, 4'h0);
        cycle_check("first_accept", vec(1'b1, 1'b0, 1'b1, 2'd3, 4'hF, 1'b1));
`else
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle_check("first_accept", vec(1'b1, 1'b0, 1'b1, 2'd3, 4'hF, 1'b1));
`endif

        // pri is now 1 in both builds
        drive(1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 4'h0);
        cycle_check("single_req0", vec(1'b1, 1'b0, 1'b1, 2'd2, 4'hA, 1'b1));
        drive(1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 4'h9);
        cycle_check("single_req1", vec(1'b0, 1'b1, 1'b1, 2'd1, 4'h9, 1'b1));

        drive(1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h9);
        cycle_check("rr_0", vec(1'b1, 1'b0, 1'b1, 2'd0, 4'h5, 1'b1));
        cycle_check("rr_1", vec(1'b0, 1'b1, 1'b1, 2'd1, 4'h9, 1'b1));
        cycle_check("rr_2", vec(1'b1, 1'b0, 1'b1, 2'd0, 4'h5, 1'b1));
        cycle_check("rr_3", vec(1'b0, 1'b1, 1'b1, 2'd1, 4'h9, 1'b1));
        cycle_check("rr_4", vec(1'b1, 1'b0, 1'b1, 2'd0, 4'h5, 1'b1));

        // pri=1; idle must not move it
        drive(1'b0, 2'd3, 4'h7, 1'b0, 2'd2, 4'h6);
        cycle_check("idle_a", IDLE);
        cycle_check("idle_b", IDLE);
        drive(1'b1, 2'd3, 4'h7, 1'b1, 2'd2, 4'h6);
        cycle_check("pri_hold", vec(1'b0, 1'b1, 1'b1, 2'd2, 4'h6, 1'b1));
        cycle_check("pri_back", vec(1'b1, 1'b0, 1'b1, 2'd3, 4'h7, 1'b1));

        // pri=1 here; reset mid-arbitration must clear it
        #2;
        rst = 1'b1;
        #1;
        check("mid_arb_reset", obs, ZEROS);
        drive(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        release_reset();
`ifdef REGFILE_WR_ARB_CLEAR_EN
        cycle_check("init_done_again", IDLE);
`endif
        drive(1'b1, 2'd1, 4'h3, 1'b1, 2'd2, 4'hC);
        cycle_check("post_reset_pri", vec(1'b1, 1'b0, 1'b1, 2'd1, 4'h3, 1'b1));
        drive(1'b0, 2'd1, 4'h3, 1'b1, 2'd2, 4'hC);
        cycle_check("req1_after", vec(1'b0, 1'b1, 1'b1, 2'd2, 4'hC, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arb_2x.md
# regfile_wr_arb_2x

Two-requester write-port arbiter and post-reset clear sequencer for the 4-word × 4-bit flat register file (one write port, one read port). It sits between two independent producers, each with a val/rdy write interface, and the regfile's single write port (wen/waddr/wdata). It grants at most one write per cycle using round-robin priority. When configured in, it first clears all four entries to zero after reset.

## Interface
Parameters:
- none; widths are fixed at 2-bit address and 4-bit data.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req0_val  in  1  requester 0 has a write pending.
- req0_rdy  out  1  requester 0 write accepted this cycle.
- req0_addr  in  2  requester 0 target word.
- req0_data  in  4  requester 0 write data.
- req1_val  in  1  requester 1 has a write pending.
- req1_rdy  out  1  requester 1 write accepted this cycle.
- req1_addr  in  2  requester 1 target word.
- req1_data  in  4  requester 1 write data.
- rf_wen  out  1  regfile write enable.
- rf_waddr  out  2  regfile write address.
- rf_wdata  out  4  regfile write data.
- init_done  out  1  high once the arbiter accepts requests.

## Operation
- State: FSM {CLEAR, ARB}, 2-bit clear counter `cnt`, 1-bit priority `pri` (0 = requester 0 wins ties).
- Reset (asynchronous): `pri`=0 and `cnt`=0. The FSM goes to CLEAR when the clear feature is built in, otherwise to ARB.
- CLEAR:
  - rf_wen=1, rf_waddr=cnt, rf_wdata=4'b0000.
  - req0_rdy=req1_rdy=0; init_done=0.
  - `cnt` increments each cycle. When `cnt`==3, the write occurs and the next state is ARB.
- ARB: init_done=1. Grant is combinational from current inputs and `pri`:
  - Only reqN_val high: grant N.
  - Both high: grant `pri`.
  - Neither high: no grant; rf_wen=0; rf_waddr and rf_wdata are 0.
- The granted requester sees reqN_rdy=1. rf_wen=1, rf_waddr=reqN_addr, rf_wdata=reqN_data. The other rdy is 0.
- A transfer happens when reqN_val && reqN_rdy. On a transfer from N, `pri` is set to the other requester on the next edge. With no transfer, `pri` holds.
- rdy never depends on the requester's own data or address, only on val and state. There are no combinational loops from rdy to val.
- Same-address requests from both sides: only one is granted per cycle, so there is no write collision inside the block.
- X on reqN_val propagates X to rf_wen, consistent with the regfile's explicit xprop.

## Timing
- Output values while rst is high: req0_rdy=0, req1_rdy=0, rf_wen=0, rf_waddr=0, rf_wdata=0, init_done=0.
- Accept latency: 0 cycles. The request is accepted in the same cycle it is presented if granted, and the regfile entry updates at that cycle's posedge.
- A denied requester must hold val, addr and data stable until it sees rdy.
- Starvation bound: a continuously asserted requester is granted within 2 cycles.
- Clear sequence: exactly 4 cycles after rst deassertion, writing addresses 0,1,2,3 in order. init_done rises in cycle 5.
- Reset asserted mid-clear or mid-arbitration aborts immediately. `cnt` and `pri` are reset, and the clear sequence restarts from address 0.
- `cnt` wraps 3→0 only on the CLEAR→ARB transition. It is unused in ARB.

## Configuration
- Macro: `REGFILE_WR_ARB_CLEAR_EN`.
- Defined: the reset state is CLEAR, and the 4-cycle zeroing sequence runs before arbitration.
- Undefined:
  - CLEAR and `cnt` are not compiled in, and reset goes directly to ARB.
  - init_done is 0 while rst is high and 1 from the first cycle after deassertion.
  - Regfile contents after reset are undefined (X).

## Test plan
- Clear (macro defined): deassert rst, hold both val=0 → rf_wen=1 with waddr 0,1,2,3 and wdata=0 for 4 cycles. Then init_done=1; regfile reads return 0 at all addresses.
- Single requester: req0 val=1, addr=2, data=4'hA, req1 idle → req0_rdy=1 same cycle; rf_wen=1, waddr=2, wdata=A; read of addr 2 returns A next cycle.
- Contention round-robin: both val=1 for 4 cycles (req0 addr0/data5, req1 addr1/data9) → grants alternate 0,1,0,1; rdy is never high on both sides at once.
- Priority memory: req1 alone granted once, then both val=1 → req0 granted first (`pri` moved to 0). Idle cycles between leave `pri` unchanged.
- Reset mid-clear: assert rst in clear cycle 3 (waddr=2) → outputs go to reset values immediately. After release, clear restarts at waddr=0 and runs a full 4 cycles.
- Macro undefined: release rst with req0 val=1, addr=3, data=4'hF → accepted in the first cycle after reset; init_done=1.
